rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 109 ++++++++++
 tb/tb_rom_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Byte-stream to word-memory loader: packs bytes little-endian into 32-bit words
// and writes them to consecutive word addresses of a 2^AW-byte target memory.
module rom_loader #(
   parameter int LOAD_WORDS = 32,
   parameter int AW         = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wen,
   output logic [31:0] w_addr_o,
   output logic [31:0] w_data_o,
   output logic        busy,
   output logic        done,
   output logic [5:0]  words_written
);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   localparam logic [5:0]    LAST_WORD = 6'(LOAD_WORDS);
   localparam logic [AW-1:0] WORD_STEP = AW'(4);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   data_q, data_d;
   logic [5:0]    words_q, words_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         words_q <= words_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      words_d = words_q;
      case (state_q)
         IDLE: begin
            // abort arriving alongside start suppresses the start
            if (start && !abort) begin
               state_d = COLLECT;
               addr_d  = '0;
               cnt_d   = '0;
               data_d  = '0;
               words_d = '0;
            end
         end
         COLLECT: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (in_valid) begin
               data_d[{cnt_q, 3'b000} +: 8] = in_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               addr_d  = addr_q + WORD_STEP;
               words_d = words_q + 6'd1;
               cnt_d   = '0;
               state_d = (words_q + 6'd1 == LAST_WORD) ? DONE : COLLECT;
            end
         end
         DONE: begin
            if (start) begin
               state_d = COLLECT;
               addr_d  = '0;
               cnt_d   = '0;
               data_d  = '0;
               words_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An abort landing on the write cycle cancels that write outright.
   assign wen           = (state_q == WRITE) && !abort;
   assign in_ready      = (state_q == COLLECT);
   assign busy          = (state_q == COLLECT) || (state_q == WRITE);
   assign done          = (state_q == DONE);
   assign w_addr_o      = {{(32-AW){1'b0}}, addr_q};
   assign w_data_o      = data_q;
   assign words_written = words_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: reset, single word, long load, stalls, aborts,
// mid-load reset; every write seen on the memory port is logged and checked.
module tb_rom_loader;

   logic        clk = 1'b0;
   logic        rst, start, abort, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, wen, busy, done;
   logic [31:0] w_addr_o, w_data_o;
   logic [5:0]  words_written;

   int checks = 0;
   int errors = 0;
   int n_wr   = 0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];

   rom_loader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wen(wen), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
      .busy(busy), .done(done), .words_written(words_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wen) begin
         n_wr++;
         q_addr.push_back(w_addr_o);
         q_data.push_back(w_data_o);
         $display("WRITE addr=%08h data=%08h", w_addr_o, w_data_o);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int cyc;
      int nb;
      int base_wr;
      logic acc;
      logic [7:0] bt;

      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_wen", {31'd0, wen}, 32'd0);
      check("rst_addr", w_addr_o, 32'd0);
      check("rst_data", w_data_o, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_words", {26'd0, words_written}, 32'd0);

      // single word
      pulse_start();
      check("collect_busy", {31'd0, busy}, 32'd1);
      check("collect_ready", {31'd0, in_ready}, 32'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      check("w1_wen", {31'd0, wen}, 32'd1);
      check("w1_ready", {31'd0, in_ready}, 32'd0);
      check("w1_addr", w_addr_o, 32'h0);
      check("w1_data", w_data_o, 32'h44332211);
      tick();
      check("w1_nwr", n_wr, 32'd1);
      check("w1_words", {26'd0, words_written}, 32'd1);
      check("w1_wen_off", {31'd0, wen}, 32'd0);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_idle", {31'd0, busy}, 32'd0);

      // abort after two bytes, then a clean word
      pulse_start();
      send_byte(8'hAA); send_byte(8'hBB);
      abort = 1'b1; tick(); abort = 1'b0;
      check("ab2_busy", {31'd0, busy}, 32'd0);
      check("ab2_ready", {31'd0, in_ready}, 32'd0);
      check("ab2_nwr", n_wr, 32'd1);
      pulse_start();
      check("restart_words", {26'd0, words_written}, 32'd0);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      check("w2_addr", w_addr_o, 32'h0);
      check("w2_data", w_data_o, 32'hDDCCBBAA);
      tick();
      check("w2_nwr", n_wr, 32'd2);

      // abort coinciding with the 4th byte
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      in_valid = 1'b1; in_data = 8'h04; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      check("ab4_busy", {31'd0, busy}, 32'd0);
      check("ab4_words", {26'd0, words_written}, 32'd1);
      check("ab4_nwr", n_wr, 32'd2);

      // abort during the write cycle
      pulse_start();
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      abort = 1'b1; #1;
      check("abw_wen", {31'd0, wen}, 32'd0);
      tick(); abort = 1'b0;
      check("abw_busy", {31'd0, busy}, 32'd0);
      check("abw_nwr", n_wr, 32'd2);
      check("abw_words", {26'd0, words_written}, 32'd0);

      // stalled stream: one byte every other cycle
      pulse_start();
      q_addr.delete(); q_data.delete();
      for (int i = 1; i <= 8; i++) begin
         bt = 8'(i);
         send_byte(bt);
         in_data = 8'hFF;
         tick();
      end
      check("stall_nwr", q_addr.size(), 32'd2);
      if (q_addr.size() == 2) begin
         check("stall_a0", q_addr[0], 32'h0);
         check("stall_d0", q_data[0], 32'h04030201);
         check("stall_a1", q_addr[1], 32'h4);
         check("stall_d1", q_data[1], 32'h08070605);
      end
      check("stall_words", {26'd0, words_written}, 32'd2);
      abort = 1'b1; tick(); abort = 1'b0;

      // full 32-word load with continuous stream
      pulse_start();
      q_addr.delete(); q_data.delete();
      nb = 0;
      cyc = 0;
      while (cyc < 200 && !done) begin
         in_valid = 1'b1;
         in_data  = 8'(nb);
         acc      = in_ready;
         tick();
         cyc++;
         if (acc) nb++;
      end
      in_valid = 1'b0;
      check("full_latency", cyc, 32'd160);
      check("full_done", {31'd0, done}, 32'd1);
      check("full_busy", {31'd0, busy}, 32'd0);
      check("full_words", {26'd0, words_written}, 32'd32);
      check("full_addr_wrap", w_addr_o, 32'h0);
      check("full_nwr", q_addr.size(), 32'd32);
      for (int j = 0; j < 32 && j < q_addr.size(); j++) begin
         check($sformatf("full_a%0d", j), q_addr[j], 32'(4 * j));
         check($sformatf("full_d%0d", j), q_data[j],
               {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
      end
      abort = 1'b1; tick(); abort = 1'b0;
      check("done_hold", {31'd0, done}, 32'd1);
      pulse_start();
      check("done_restart_busy", {31'd0, busy}, 32'd1);
      check("done_restart_done", {31'd0, done}, 32'd0);
      check("done_restart_words", {26'd0, words_written}, 32'd0);

      // reset mid-collect
      base_wr = n_wr;
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mrst_ready", {31'd0, in_ready}, 32'd0);
      check("mrst_wen", {31'd0, wen}, 32'd0);
      check("mrst_addr", w_addr_o, 32'd0);
      check("mrst_data", w_data_o, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_done", {31'd0, done}, 32'd0);
      check("mrst_words", {26'd0, words_written}, 32'd0);
      check("mrst_nwr", n_wr, base_wr);

      // reset and abort both beat start
      rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
      check("rst_vs_start", {31'd0, busy}, 32'd0);
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      check("abort_vs_start", {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
